// File: rtl/chord_sequencer.sv
// chord_sequencer: walks the song ROM and feeds note events to
// three voice players, pacing playback with 1/48 s beat pulses.
module chord_sequencer #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              restart,
  input  logic              beat,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              done_with_note1,
  input  logic              done_with_note2,
  input  logic              done_with_note3,
  output logic [5:0]        note_to_load1,
  output logic [5:0]        note_to_load2,
  output logic [5:0]        note_to_load3,
  output logic [5:0]        duration_to_load1,
  output logic [5:0]        duration_to_load2,
  output logic [5:0]        duration_to_load3,
  output logic              load_new_note1,
  output logic              load_new_note2,
  output logic              load_new_note3,
  output logic              song_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DISPATCH,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nx;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic [5:0]          r_cnt;
  logic [5:0]          w_cnt_nx;
  logic [1:0]          r_voice;
  logic [5:0]          r_wnote;
  logic [5:0]          r_wdur;
  logic [2:0][5:0]     r_note;
  logic [2:0][5:0]     r_dur;
  logic                w_latch;
  logic                w_adv;
  logic                w_zero;
  logic                w_end;
  logic [2:0]          w_sel;
  logic [2:0]          w_done;
  logic [2:0]          w_load;
  logic                w_unused;

  assign w_unused   = rom_data[12];
  assign w_adv      = rom_data[15];
  assign w_zero     = (rom_data[5:0] == 6'd0);
  assign w_end      = (rom_data[14:13] == 2'd3);
  assign w_addr_inc = r_addr + ADDR_W'(1);
  assign w_done     = {done_with_note3, done_with_note2, done_with_note1};
  assign w_sel      = {r_voice == 2'd2, r_voice == 2'd1, r_voice == 2'd0};

  // Strobe the selected voice only while running and the voice is idle
  always_comb begin
    w_load = 3'b000;
    if (r_state == S_DISPATCH && play_enable && !restart)
      w_load = w_sel & w_done;
  end

  // Next-state, address and beat-counter decisions
  always_comb begin
    w_next    = r_state;
    w_addr_nx = r_addr;
    w_cnt_nx  = r_cnt;
    w_latch   = 1'b0;
    if (restart) begin
      w_next    = play_enable ? S_FETCH : S_IDLE;
      w_addr_nx = '0;
      w_cnt_nx  = 6'd0;
    end else if (play_enable) begin
      unique case (r_state)
        S_IDLE:   w_next = S_FETCH;
        S_FETCH:  w_next = S_DECODE;
        S_DECODE: begin
          w_latch = 1'b1;
          unique case (1'b1)
            w_adv && w_zero: begin
              w_addr_nx = w_addr_inc;
              w_next    = S_FETCH;
            end
            w_adv && !w_zero: begin
              w_cnt_nx = rom_data[5:0];
              w_next   = S_ADVANCE;
            end
            !w_adv && w_end: w_next = S_DONE;
            default:         w_next = S_DISPATCH;
          endcase
        end
        S_DISPATCH: begin
          if (|w_load) begin
            w_addr_nx = w_addr_inc;
            w_next    = S_FETCH;
          end
        end
        S_ADVANCE: begin
          if (beat) begin
            w_cnt_nx = r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
              w_addr_nx = w_addr_inc;
              w_next    = S_FETCH;
            end
          end
        end
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // State, address, counter, decoded word and per-voice registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= 6'd0;
      r_voice <= 2'd0;
      r_wnote <= 6'd0;
      r_wdur  <= 6'd0;
      r_note  <= '0;
      r_dur   <= '0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr_nx;
      r_cnt   <= w_cnt_nx;
      if (w_latch) begin
        r_voice <= rom_data[14:13];
        r_wnote <= rom_data[11:6];
        r_wdur  <= rom_data[5:0];
      end
      for (int i = 0; i < 3; i++) begin
        if (w_load[i]) begin
          r_note[i] <= r_wnote;
          r_dur[i]  <= r_wdur;
        end
      end
    end
  end

  assign rom_addr = r_addr;
  assign song_done = (r_state == S_DONE);
  assign load_new_note1 = w_load[0];
  assign load_new_note2 = w_load[1];
  assign load_new_note3 = w_load[2];
  assign note_to_load1 = w_load[0] ? r_wnote : r_note[0];
  assign note_to_load2 = w_load[1] ? r_wnote : r_note[1];
  assign note_to_load3 = w_load[2] ? r_wnote : r_note[2];
  assign duration_to_load1 = w_load[0] ? r_wdur : r_dur[0];
  assign duration_to_load2 = w_load[1] ? r_wdur : r_dur[1];
  assign duration_to_load3 = w_load[2] ? r_wdur : r_dur[2];

endmodule

// File: tb/tb_chord_sequencer.sv
// tb_chord_sequencer: vector tables for the scripted scenarios plus
// a random song checked against a word-walking reference model.
module tb_chord_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pe = 1'b0;
  logic        rs = 1'b0;
  logic        bt = 1'b0;
  logic [2:0]  dn = 3'b111;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data = 16'h0;
  logic [5:0]  n1, n2, n3, d1, d2, d3;
  logic        ld1, ld2, ld3, sd;
  logic [15:0] rom [128];

  logic        pe2 = 1'b0;
  logic        zero2 = 1'b0;
  logic [1:0]  rom_addr2;
  logic [15:0] rom_data2 = 16'h0;
  logic [5:0]  m1, m2, m3, e1, e2, e3;
  logic        k1, k2, k3, sd2;
  logic [15:0] rom2 [4];

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) rom_data2 <= rom2[rom_addr2];

  chord_sequencer #(.ADDR_W(7)) dut (
    .clk(clk), .reset(reset), .play_enable(pe), .restart(rs),
    .beat(bt), .rom_addr(rom_addr), .rom_data(rom_data),
    .done_with_note1(dn[0]), .done_with_note2(dn[1]),
    .done_with_note3(dn[2]),
    .note_to_load1(n1), .note_to_load2(n2), .note_to_load3(n3),
    .duration_to_load1(d1), .duration_to_load2(d2),
    .duration_to_load3(d3),
    .load_new_note1(ld1), .load_new_note2(ld2),
    .load_new_note3(ld3), .song_done(sd)
  );

  chord_sequencer #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .play_enable(pe2), .restart(zero2),
    .beat(zero2), .rom_addr(rom_addr2), .rom_data(rom_data2),
    .done_with_note1(1'b1), .done_with_note2(1'b1),
    .done_with_note3(1'b1),
    .note_to_load1(m1), .note_to_load2(m2), .note_to_load3(m3),
    .duration_to_load1(e1), .duration_to_load2(e2),
    .duration_to_load3(e3),
    .load_new_note1(k1), .load_new_note2(k2),
    .load_new_note3(k3), .song_done(sd2)
  );

  typedef struct {
    bit       pe;
    bit       rs;
    bit       bt;
    bit [2:0] dn;
    int       addr;
    bit [2:0] ld;
    bit       sd;
    int       note;
    int       dur;
  } vec_t;

  typedef struct {
    int       v;
    bit [5:0] n;
    bit [5:0] d;
  } ld_t;

  vec_t tbl[$];
  ld_t  exq[$];

  task automatic add(bit p, bit r, bit b, bit [2:0] d, int a,
                     bit [2:0] l, bit s, int nt = 0, int du = 0);
    vec_t v;
    v.pe = p; v.rs = r; v.bt = b; v.dn = d;
    v.addr = a; v.ld = l; v.sd = s; v.note = nt; v.dur = du;
    tbl.push_back(v);
  endtask

  task automatic chk(string nm, int got, int exp);
    nvec++;
    if (got != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic apply(string nm, vec_t v, int idx);
    bit [2:0] gl;
    int gn, gd;
    bit ok;
    pe = v.pe; rs = v.rs; bt = v.bt; dn = v.dn;
    #4;
    gl = {ld3, ld2, ld1};
    gn = v.ld[2] ? int'(n3) : v.ld[1] ? int'(n2) : int'(n1);
    gd = v.ld[2] ? int'(d3) : v.ld[1] ? int'(d2) : int'(d1);
    ok = (int'(rom_addr) == v.addr) && (gl == v.ld) && (sd == v.sd);
    if (v.ld != 3'b000 && (gn != v.note || gd != v.dur)) ok = 1'b0;
    nvec++;
    if (!ok) begin
      nbad++;
      $display("FAIL %s[%0d]: addr=%0d ld=%b done=%b note=%0d dur=%0d, expected addr=%0d ld=%b done=%b note=%0d dur=%0d",
               nm, idx, rom_addr, gl, sd, gn, gd,
               v.addr, v.ld, v.sd, v.note, v.dur);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_table(string nm);
    foreach (tbl[i]) apply(nm, tbl[i], i);
    tbl.delete();
  endtask

  task automatic step(bit p, bit r, bit b, bit [2:0] d);
    pe = p; rs = r; bt = b; dn = d;
    @(posedge clk); #1;
  endtask

  task automatic to_idle();
    step(1'b0, 1'b1, 1'b0, 3'b111);
    rs = 1'b0;
  endtask

  task automatic stall_table();
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    for (int i = 0; i < 10; i++)
      add(1, 0, 0, 3'b101, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b010, 0, 9, 3);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b000, 1);
    run_table("stall");
  endtask

  initial begin
    int got, cnt, last, saw_wrap, L, cyc;
    bit [2:0] gl;
    int v;
    ld_t e;
    logic [15:0] w;

    foreach (rom[i]) rom[i] = 16'h6000;
    foreach (rom2[i]) rom2[i] = {4'b0000, 6'(i + 1), 6'd1};

    // basic song: v1 5/12, v2 9/3, end
    rom[0] = 16'h014C;
    rom[1] = 16'h2243;
    rom[2] = 16'h6000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    add(0, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b001, 0, 5, 12);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b010, 0, 9, 3);
    add(1, 0, 0, 3'b111, 2, 3'b000, 0);
    add(1, 0, 0, 3'b111, 2, 3'b000, 0);
    add(1, 0, 0, 3'b111, 2, 3'b000, 1);
    add(1, 0, 0, 3'b111, 2, 3'b000, 1);
    add(1, 1, 0, 3'b111, 2, 3'b000, 1);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 1, 0, 3'b000, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b001, 0, 5, 12);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    run_table("basic");

    // advance song: note, wait 3, wait 0, note, end
    to_idle();
    rom[0] = 16'h014C;
    rom[1] = 16'h8003;
    rom[2] = 16'h8000;
    rom[3] = 16'h2243;
    rom[4] = 16'h6000;
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 1, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b001, 0, 5, 12);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 1, 3'b111, 1, 3'b000, 0);
    add(1, 0, 1, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 1, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 1, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 2, 3'b000, 0);
    add(1, 0, 0, 3'b111, 2, 3'b000, 0);
    add(1, 0, 0, 3'b111, 3, 3'b000, 0);
    add(1, 0, 0, 3'b111, 3, 3'b000, 0);
    add(1, 0, 0, 3'b111, 3, 3'b010, 0, 9, 3);
    add(1, 0, 0, 3'b111, 4, 3'b000, 0);
    add(1, 0, 0, 3'b111, 4, 3'b000, 0);
    add(1, 0, 0, 3'b111, 4, 3'b000, 1);
    run_table("advance");

    // freeze mid-advance with beats arriving while disabled
    to_idle();
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b000, 0);
    add(1, 0, 0, 3'b111, 0, 3'b001, 0, 5, 12);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 1, 3'b111, 1, 3'b000, 0);
    add(0, 0, 1, 3'b111, 1, 3'b000, 0);
    add(0, 0, 0, 3'b111, 1, 3'b000, 0);
    add(0, 0, 1, 3'b111, 1, 3'b000, 0);
    add(0, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 1, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 1, 3'b000, 0);
    add(1, 0, 1, 3'b111, 1, 3'b000, 0);
    add(1, 0, 0, 3'b111, 2, 3'b000, 0);
    run_table("freeze");

    // voice 2 busy for 10 cycles
    to_idle();
    rom[0] = 16'h2243;
    rom[1] = 16'h6000;
    stall_table();

    // async reset while a strobe is high mid-dispatch
    to_idle();
    step(1'b1, 1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 3'b000);
    step(1'b1, 1'b0, 1'b0, 3'b000);
    dn = 3'b010;
    #2;
    chk("pre_reset_strobe", int'({ld3, ld2, ld1}), 2);
    reset = 1'b0;
    #1;
    chk("async_ld", int'({ld3, ld2, ld1}), 0);
    chk("async_addr", int'(rom_addr), 0);
    chk("async_note1", int'(n1), 0);
    chk("async_note2", int'(n2), 0);
    chk("async_done", int'(sd), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    dn = 3'b111;
    stall_table();

    // 2-bit address wraps without an end-of-song word
    pe = 1'b0;
    pe2 = 1'b1;
    got = 0;
    saw_wrap = 0;
    last = 0;
    for (int c = 0; c < 80 && got < 6; c++) begin
      #4;
      if (last == 3 && rom_addr2 == 2'd0) saw_wrap = 1;
      last = int'(rom_addr2);
      if (k1 || k2 || k3) begin
        chk("wrap_voice", int'({k3, k2, k1}), 1);
        chk("wrap_note", int'(m1), (got % 4) + 1);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("wrap_count", got, 6);
    chk("wrap_seen", saw_wrap, 1);
    chk("wrap_no_done", int'(sd2), 0);
    pe2 = 1'b0;

    // random song against the word-walking model
    to_idle();
    L = 30;
    foreach (rom[i]) rom[i] = {3'b011, 13'($urandom)};
    for (int i = 0; i < L; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cnt = $urandom_range(0, 3);
        rom[i] = {1'b1, 9'($urandom), 6'(cnt)};
      end else begin
        e.v = $urandom_range(0, 2);
        e.n = 6'($urandom);
        e.d = 6'($urandom);
        rom[i] = {1'b0, 2'(e.v), 1'($urandom), e.n, e.d};
        exq.push_back(e);
      end
    end
    cyc = 0;
    while (cyc < 8000 && !sd) begin
      pe = ($urandom_range(0, 9) != 0);
      bt = ($urandom_range(0, 3) == 0);
      dn = 3'($urandom);
      #4;
      gl = {ld3, ld2, ld1};
      if (gl != 3'b000) begin
        v = gl[2] ? 2 : gl[1] ? 1 : 0;
        w = {8'h00, (gl[2] ? n3 : gl[1] ? n2 : n1),
             2'b00};
        nvec++;
        if (exq.size() == 0) begin
          nbad++;
          $display("FAIL rand_extra: strobe %b with no note left", gl);
        end else begin
          e = exq.pop_front();
          if (!$onehot(gl) || !pe || !dn[v] || v != e.v ||
              w[7:2] != e.n ||
              (gl[2] ? d3 : gl[1] ? d2 : d1) != e.d) begin
            nbad++;
            $display("FAIL rand_load: ld=%b pe=%b dn=%b note=%0d, expected voice %0d note=%0d dur=%0d",
                     gl, pe, dn, w[7:2], e.v + 1, e.n, e.d);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_song_done", int'(sd), 1);
    chk("rand_left", exq.size(), 0);
    chk("rand_end_addr", int'(rom_addr), L);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
